// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, ALU codes,
// instruction fields, datapath mux selects and the per-state Moore control table.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WBSRC_ALUOUT = 2'd0;
  localparam logic [1:0] WBSRC_MDR    = 2'd1;
  localparam logic [1:0] WBSRC_PC     = 2'd2;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  localparam logic [1:0] SRCB_RT         = 2'd0;
  localparam logic [1:0] SRCB_FOUR       = 2'd1;
  localparam logic [1:0] SRCB_IMM_ZX     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SX_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       done;
  } ctrl_t;

  // Handshake-dependent strobes (fetch accept, branch, store completion) are added in the top.
  function automatic ctrl_t stateControls(input state_t s, input logic [5:0] opcode,
                                          input logic [2:0] rAluOp);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM_SX_SH2;
        c.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = rAluOp;
      end
      EXEC_I: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_IMM_ZX;
        c.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      MEM_ADDR: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_IMM_ZX;
        c.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RD;
        c.wb_src    = WBSRC_ALUOUT;
        c.done      = 1'b1;
      end
      WB_I: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RT;
        c.wb_src    = WBSRC_ALUOUT;
        c.done      = 1'b1;
      end
      WB_MEM: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RT;
        c.wb_src    = WBSRC_MDR;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        c.done      = 1'b1;
      end
      JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      JAL: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_R31;
        c.wb_src    = WBSRC_PC;
        c.pc_src    = PCSRC_JUMP;
        c.pc_write  = 1'b1;
        c.done      = 1'b1;
      end
      JR: begin
        c.pc_src   = PCSRC_RS;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// R-type funct decoder: maps the arithmetic/logic funct codes onto ALU operations
// and flags any funct this ALU cannot execute.
module multicycle_ctrl_alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ALU_ADD;
    o_legal  = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode, execute, memory
// and write-back steps and drives the datapath enables and mux selects.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t     r_state;
  ctrl_t      r_ctrl;
  state_t     w_nextState;
  state_t     w_decodeTarget;
  logic       w_decodeLegal;
  logic [2:0] w_fnAluOp;
  logic       w_fnLegal;
  logic       w_fetchAccept;
  logic       w_branchTaken;
  logic       w_memWrDone;
  logic       w_illegal;
  logic       w_active;

  multicycle_ctrl_alu_decode u_aluDecode (
    .i_funct  (funct),
    .o_alu_op (w_fnAluOp),
    .o_legal  (w_fnLegal)
  );

  always_comb begin
    w_decodeTarget = FETCH;
    w_decodeLegal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR)  w_decodeTarget = JR;
        else if (w_fnLegal)  w_decodeTarget = EXEC_R;
        else                 w_decodeLegal  = 1'b0;
      end
      OP_LW, OP_SW:     w_decodeTarget = MEM_ADDR;
      OP_BEQ, OP_BNE:   w_decodeTarget = BRANCH;
      OP_ADDI, OP_ORI:  w_decodeTarget = EXEC_I;
      OP_J:             w_decodeTarget = JUMP;
      OP_JAL:           w_decodeTarget = JAL;
      default:          w_decodeLegal  = 1'b0;
    endcase
  end

  // Memory states wait on mem_ready; all terminal states fall back to FETCH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:    if (mem_ready) w_nextState = DECODE;
      DECODE:   w_nextState = w_decodeTarget;
      EXEC_R:   w_nextState = WB_R;
      EXEC_I:   w_nextState = WB_I;
      MEM_ADDR: w_nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) w_nextState = WB_MEM;
      MEM_WR:   if (mem_ready) w_nextState = FETCH;
      default:  w_nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_ctrl  <= stateControls(FETCH, OP_RTYPE, ALU_ADD);
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= stateControls(w_nextState, opcode, w_fnAluOp);
    end
  end

  assign w_fetchAccept = (r_state == FETCH) && mem_ready;
  assign w_branchTaken = (r_state == BRANCH) && ((opcode == OP_BNE) ? ~zero : zero);
  assign w_memWrDone   = (r_state == MEM_WR) && mem_ready;
  assign w_illegal     = (r_state == DECODE) && !w_decodeLegal;
  assign w_active      = ~reset;

  // Every output is forced low while reset is held, even before the reset edge lands.
  assign pc_write   = w_active & (r_ctrl.pc_write | w_fetchAccept | w_branchTaken);
  assign ir_write   = w_active & w_fetchAccept;
  assign reg_write  = w_active & r_ctrl.reg_write;
  assign mem_read   = w_active & r_ctrl.mem_read;
  assign mem_write  = w_active & r_ctrl.mem_write;
  assign i_or_d     = w_active & r_ctrl.i_or_d;
  assign reg_dst    = {2{w_active}} & r_ctrl.reg_dst;
  assign wb_src     = {2{w_active}} & r_ctrl.wb_src;
  assign alu_src_a  = w_active & r_ctrl.alu_src_a;
  assign alu_src_b  = {2{w_active}} & r_ctrl.alu_src_b;
  assign alu_op     = {3{w_active}} & r_ctrl.alu_op;
  assign pc_src     = {2{w_active}} & r_ctrl.pc_src;
  assign instr_done = w_active & (r_ctrl.done | w_memWrDone | w_illegal);
  assign illegal    = w_active & w_illegal;
  assign state_dbg  = {4{w_active}} & r_state;

endmodule
